// File: rtl/rvv_backend_div_sched.sv
// -----------------------------------------------------------------------------
// rvv_backend_div_sched
//
// Scheduler between the DIV reservation-station FIFO and a pool of NUM_UNIT
// variable-latency iterative divide units. Uops are issued to the units in
// round-robin order. Each finished result is held in a per-unit slot until the
// ROB accepts it. Results leave in program order even though the units can
// finish out of order.
//
// Ports
//   clk, rst              : clock; asynchronous active-high reset
//   uop_valid_rs2sch      : RS FIFO head valid
//   uop_rs2sch            : RS FIFO head uop
//   pop_sch2rs            : pop RS FIFO head this cycle
//   unit_start            : one-hot start pulse, one bit per divide unit
//   unit_uop              : uop broadcast to all units, qualified by unit_start
//   unit_done             : per-unit one-cycle completion pulse
//   unit_result           : per-unit result (flattened), valid with unit_done
//   result_valid_ex2rob   : in-order result available to ROB
//   result_ex2rob         : in-order result payload
//   result_ready_rob2div  : ROB accepts the presented result
//   trap_flush_rvv        : trap flush, drops all in-flight work
//   div_idle              : every slot is IDLE
// -----------------------------------------------------------------------------
module rvv_backend_div_sched #(
  parameter int NUM_UNIT = 2,
  parameter int UOP_W    = 64,
  parameter int RES_W    = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      uop_valid_rs2sch,
  input  logic [UOP_W-1:0]          uop_rs2sch,
  output logic                      pop_sch2rs,
  output logic [NUM_UNIT-1:0]       unit_start,
  output logic [UOP_W-1:0]          unit_uop,
  input  logic [NUM_UNIT-1:0]       unit_done,
  input  logic [NUM_UNIT*RES_W-1:0] unit_result,
  output logic                      result_valid_ex2rob,
  output logic [RES_W-1:0]          result_ex2rob,
  input  logic                      result_ready_rob2div,
  input  logic                      trap_flush_rvv,
  output logic                      div_idle
);

  localparam int PTR_W = $clog2(NUM_UNIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } slot_state_e;

  // Slot state and captured results, one slot per divide unit
  slot_state_e      r_state [NUM_UNIT];
  logic [RES_W-1:0] r_res   [NUM_UNIT];
  logic [PTR_W-1:0] r_iss_ptr;
  logic [PTR_W-1:0] r_ret_ptr;

  // Next-state values
  slot_state_e      w_state_nxt [NUM_UNIT];
  logic [RES_W-1:0] w_res_nxt   [NUM_UNIT];
  logic [PTR_W-1:0] w_iss_ptr_nxt;
  logic [PTR_W-1:0] w_ret_ptr_nxt;

  logic                w_issue;
  logic                w_head_done;
  logic                w_retire;
  logic [NUM_UNIT-1:0] w_start;
  logic                w_all_idle;

  // Issue decode: only the slot under iss_ptr may take the FIFO head, so a
  // busy target stalls issue even when other slots are free. Reset gates the
  // start so the units never see a pulse while the scheduler is held.
  always_comb begin
    w_issue = 1'b0;
    if (uop_valid_rs2sch && (r_state[r_iss_ptr] == S_IDLE) && !trap_flush_rvv && !rst) begin
      w_issue = 1'b1;
    end else begin
      w_issue = 1'b0;
    end
    for (int k = 0; k < NUM_UNIT; k++) begin
      w_start[k] = w_issue && (r_iss_ptr == PTR_W'(k));
    end
  end

  // Retire decode: the head of the in-order stream is the slot under ret_ptr
  always_comb begin
    w_head_done = (r_state[r_ret_ptr] == S_DONE);
    w_retire    = w_head_done && result_ready_rob2div && !trap_flush_rvv;
  end

  // Slot and pointer next-state. A slot is IDLE, BUSY or DONE, so issue,
  // capture and retire can never collide on the same slot in one cycle.
  // A done pulse on a slot that is not BUSY (stale after flush/reset) is
  // dropped. Flush discards everything; res_q keeps its old contents since
  // nothing reads it until a new capture.
  always_comb begin
    w_iss_ptr_nxt = r_iss_ptr;
    w_ret_ptr_nxt = r_ret_ptr;
    for (int k = 0; k < NUM_UNIT; k++) begin
      w_state_nxt[k] = r_state[k];
      w_res_nxt[k]   = r_res[k];
    end

    if (trap_flush_rvv) begin
      for (int k = 0; k < NUM_UNIT; k++) begin
        w_state_nxt[k] = S_IDLE;
      end
      w_iss_ptr_nxt = '0;
      w_ret_ptr_nxt = '0;
    end else begin
      for (int k = 0; k < NUM_UNIT; k++) begin
        case (r_state[k])
          S_IDLE: begin
            if (w_start[k]) begin
              w_state_nxt[k] = S_BUSY;
            end else begin
              w_state_nxt[k] = S_IDLE;
            end
          end
          S_BUSY: begin
            if (unit_done[k]) begin
              w_state_nxt[k] = S_DONE;
              w_res_nxt[k]   = unit_result[k*RES_W +: RES_W];
            end else begin
              w_state_nxt[k] = S_BUSY;
            end
          end
          S_DONE: begin
            if (w_retire && (r_ret_ptr == PTR_W'(k))) begin
              w_state_nxt[k] = S_IDLE;
            end else begin
              w_state_nxt[k] = S_DONE;
            end
          end
          default: begin
            w_state_nxt[k] = S_IDLE;
          end
        endcase
      end

      // Pointers are log2(NUM_UNIT) bits wide, so the increment wraps
      if (w_issue) begin
        w_iss_ptr_nxt = r_iss_ptr + PTR_W'(1);
      end else begin
        w_iss_ptr_nxt = r_iss_ptr;
      end
      if (w_retire) begin
        w_ret_ptr_nxt = r_ret_ptr + PTR_W'(1);
      end else begin
        w_ret_ptr_nxt = r_ret_ptr;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_UNIT; k++) begin
        r_state[k] <= S_IDLE;
        r_res[k]   <= '0;
      end
      r_iss_ptr <= '0;
      r_ret_ptr <= '0;
    end else begin
      for (int k = 0; k < NUM_UNIT; k++) begin
        r_state[k] <= w_state_nxt[k];
        r_res[k]   <= w_res_nxt[k];
      end
      r_iss_ptr <= w_iss_ptr_nxt;
      r_ret_ptr <= w_ret_ptr_nxt;
    end
  end

  // Idle detect over the registered slot states
  always_comb begin
    w_all_idle = 1'b1;
    for (int k = 0; k < NUM_UNIT; k++) begin
      w_all_idle = w_all_idle && (r_state[k] == S_IDLE);
    end
  end

  assign unit_start          = w_start;
  assign pop_sch2rs          = w_issue;
  assign unit_uop            = uop_rs2sch;
  assign result_valid_ex2rob = w_head_done;
  assign result_ex2rob       = r_res[r_ret_ptr];
  assign div_idle            = w_all_idle;

endmodule

// File: tb/tb_rvv_backend_div_sched.sv
// -----------------------------------------------------------------------------
// tb_rvv_backend_div_sched
//
// Bench for rvv_backend_div_sched with four divide units. The bench emulates
// the divide units (result = uop ^ 0x0010 after a chosen latency) and keeps a
// reference model: an in-order queue of in-flight uops, each tagged with the
// unit it went to, a done flag and its captured result. The model is checked
// against the DUT every cycle; directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_rvv_backend_div_sched;

  localparam int NU = 4;
  localparam int UW = 16;
  localparam int RW = 16;

  logic             clk;
  logic             rst;
  logic             uop_valid_rs2sch;
  logic [UW-1:0]    uop_rs2sch;
  logic             pop_sch2rs;
  logic [NU-1:0]    unit_start;
  logic [UW-1:0]    unit_uop;
  logic [NU-1:0]    unit_done;
  logic [NU*RW-1:0] unit_result;
  logic             result_valid_ex2rob;
  logic [RW-1:0]    result_ex2rob;
  logic             result_ready_rob2div;
  logic             trap_flush_rvv;
  logic             div_idle;

  rvv_backend_div_sched #(
    .NUM_UNIT(NU),
    .UOP_W   (UW),
    .RES_W   (RW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .uop_valid_rs2sch    (uop_valid_rs2sch),
    .uop_rs2sch          (uop_rs2sch),
    .pop_sch2rs          (pop_sch2rs),
    .unit_start          (unit_start),
    .unit_uop            (unit_uop),
    .unit_done           (unit_done),
    .unit_result         (unit_result),
    .result_valid_ex2rob (result_valid_ex2rob),
    .result_ex2rob       (result_ex2rob),
    .result_ready_rob2div(result_ready_rob2div),
    .trap_flush_rvv      (trap_flush_rvv),
    .div_idle            (div_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] fres(input logic [UW-1:0] u);
    return u ^ 16'h0010;
  endfunction

  // ---------------- divide-unit emulation ----------------
  logic [NU-1:0] cap_start;
  logic [UW-1:0] cap_uop;
  int            cap_lat;
  int            fixed_lat;
  int            env_cnt  [NU];
  logic [UW-1:0] env_uop  [NU];
  bit            env_busy [NU];

  // Capture start pulses mid-cycle; latency is fixed_lat or random 1..20
  always @(negedge clk) begin
    cap_start = rst ? '0 : unit_start;
    cap_uop   = unit_uop;
    cap_lat   = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(20, 1));
  end

  // Units count down and pulse done; result bus carries noise otherwise.
  // Units keep running through flush/reset so stale dones do happen.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NU; k++) begin
      if (cap_start[k]) begin
        env_busy[k] = 1'b1;
        env_cnt[k]  = cap_lat;
        env_uop[k]  = cap_uop;
      end
      unit_done[k] = 1'b0;
      unit_result[k*RW +: RW] = RW'($urandom);
      if (env_busy[k]) begin
        env_cnt[k] = env_cnt[k] - 1;
        if (env_cnt[k] == 0) begin
          env_busy[k] = 1'b0;
          unit_done[k] = 1'b1;
          unit_result[k*RW +: RW] = fres(env_uop[k]);
        end
      end
    end
  end

  // ---------------- reference model and checking ----------------
  int            checks;
  int            failures;
  int            m_unit [$];
  bit            m_done [$];
  logic [RW-1:0] m_res  [$];
  int            m_iss;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_unit.delete();
    m_done.delete();
    m_res.delete();
    m_iss = 0;
  endtask

  // Compare DUT against the model for the current cycle, then advance it
  task automatic model_step();
    int            n;
    bit            e_pop;
    bit            e_valid;
    logic [NU-1:0] e_start;
    if (rst) begin
      model_clear();
      chk("m_rst_pop", pop_sch2rs, 1'b0);
      chk("m_rst_start", unit_start, '0);
      chk("m_rst_valid", result_valid_ex2rob, 1'b0);
      chk("m_rst_data", result_ex2rob, '0);
      chk("m_rst_idle", div_idle, 1'b1);
    end else begin
      n       = m_unit.size();
      e_pop   = uop_valid_rs2sch && (n < NU) && !trap_flush_rvv;
      e_start = '0;
      if (e_pop) e_start[m_iss] = 1'b1;
      e_valid = (n > 0) && m_done[0];
      chk("m_pop", pop_sch2rs, e_pop);
      chk("m_start", unit_start, e_start);
      if (e_pop) chk("m_uop", unit_uop, uop_rs2sch);
      chk("m_valid", result_valid_ex2rob, e_valid);
      if (e_valid) chk("m_data", result_ex2rob, m_res[0]);
      chk("m_idle", div_idle, n == 0);
      if (trap_flush_rvv) begin
        model_clear();
      end else begin
        if (e_valid && result_ready_rob2div) begin
          void'(m_unit.pop_front());
          void'(m_done.pop_front());
          void'(m_res.pop_front());
        end
        for (int k = 0; k < NU; k++) begin
          if (unit_done[k] === 1'b1) begin
            for (int i = 0; i < m_unit.size(); i++) begin
              if (m_unit[i] == k && !m_done[i]) begin
                m_done[i] = 1'b1;
                m_res[i]  = unit_result[k*RW +: RW];
              end
            end
          end
        end
        if (e_pop) begin
          m_unit.push_back(m_iss);
          m_done.push_back(1'b0);
          m_res.push_back('0);
          m_iss = (m_iss + 1) % NU;
        end
      end
    end
  endtask

  // One cycle: model check at negedge, return just after the next posedge
  task automatic nc();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_outputs(input string nm);
    chk({nm, "_pop"}, pop_sch2rs, 1'b0);
    chk({nm, "_start"}, unit_start, '0);
    chk({nm, "_valid"}, result_valid_ex2rob, 1'b0);
    chk({nm, "_data"}, result_ex2rob, '0);
    chk({nm, "_idle"}, div_idle, 1'b1);
  endtask

  int remain;
  int pops;
  int rets;
  bit popped;

  // Random traffic; flush_rate 0 disables flushes, uop_limit<0 is unlimited
  task automatic random_run(input int cycles, input int flush_rate, input int uop_limit);
    remain = uop_limit;
    pops   = 0;
    rets   = 0;
    popped = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (uop_limit >= 0 && rets >= uop_limit) break;
      if (popped) uop_valid_rs2sch = 1'b0;
      if (!uop_valid_rs2sch && remain != 0 && $urandom_range(3, 0) != 0) begin
        uop_valid_rs2sch = 1'b1;
        uop_rs2sch       = UW'($urandom);
      end
      result_ready_rob2div = ($urandom_range(2, 0) != 0);
      trap_flush_rvv = (flush_rate > 0) && ($urandom_range(flush_rate - 1, 0) == 0);
      #1;
      popped = pop_sch2rs;
      if (popped) begin
        pops++;
        if (remain > 0) remain--;
      end
      if (result_valid_ex2rob && result_ready_rob2div && !trap_flush_rvv) rets++;
      nc();
    end
    uop_valid_rs2sch = 1'b0;
    trap_flush_rvv   = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_iss = 0;
    fixed_lat = 0;
    rst = 1'b1;
    uop_valid_rs2sch = 1'b0;
    uop_rs2sch = '0;
    result_ready_rob2div = 1'b0;
    trap_flush_rvv = 1'b0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_outputs("reset");
    nc();
    rst = 1'b0;
    nc();

    // Single uop: start[0]+pop same cycle, result 0x11 one cycle after done
    uop_valid_rs2sch = 1'b1;
    uop_rs2sch = 16'h0001;
    result_ready_rob2div = 1'b1;
    fixed_lat = 5;
    #1;
    chk("t1_start", unit_start, 4'b0001);
    chk("t1_pop", pop_sch2rs, 1'b1);
    nc();
    uop_valid_rs2sch = 1'b0;
    fixed_lat = 0;
    repeat (4) nc();
    #1;
    chk("t1_valid_on_done", result_valid_ex2rob, 1'b0);
    nc();
    #1;
    chk("t1_valid", result_valid_ex2rob, 1'b1);
    chk("t1_data", result_ex2rob, 16'h0011);
    nc();
    #1;
    chk("t1_idle", div_idle, 1'b1);

    // Out-of-order completion: B finishes first, ROB still sees A then B
    trap_flush_rvv = 1'b1;
    nc();
    trap_flush_rvv = 1'b0;
    result_ready_rob2div = 1'b0;
    uop_valid_rs2sch = 1'b1;
    uop_rs2sch = 16'h001A;
    fixed_lat = 6;
    #1;
    chk("t2_startA", unit_start, 4'b0001);
    nc();
    uop_rs2sch = 16'h001B;
    fixed_lat = 2;
    #1;
    chk("t2_startB", unit_start, 4'b0010);
    nc();
    uop_valid_rs2sch = 1'b0;
    fixed_lat = 0;
    repeat (3) nc();
    #1;
    chk("t2_no_early", result_valid_ex2rob, 1'b0);
    repeat (2) nc();
    result_ready_rob2div = 1'b1;
    #1;
    chk("t2_validA", result_valid_ex2rob, 1'b1);
    chk("t2_dataA", result_ex2rob, 16'h000A);
    nc();
    #1;
    chk("t2_validB", result_valid_ex2rob, 1'b1);
    chk("t2_dataB", result_ex2rob, 16'h000B);
    nc();
    #1;
    chk("t2_idle", div_idle, 1'b1);

    // Full stall: all slots DONE, ROB not ready, FIFO still valid
    trap_flush_rvv = 1'b1;
    nc();
    trap_flush_rvv = 1'b0;
    result_ready_rob2div = 1'b0;
    uop_valid_rs2sch = 1'b1;
    fixed_lat = 1;
    for (int i = 0; i < NU; i++) begin
      uop_rs2sch = 16'h0020 + UW'(i);
      #1;
      chk("t3_fill_pop", pop_sch2rs, 1'b1);
      nc();
    end
    uop_rs2sch = 16'h0024;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_hold_pop", pop_sch2rs, 1'b0);
      chk("t3_hold_valid", result_valid_ex2rob, 1'b1);
      chk("t3_hold_data", result_ex2rob, 16'h0030);
      nc();
    end
    result_ready_rob2div = 1'b1;
    #1;
    chk("t3_retire_pop", pop_sch2rs, 1'b0);
    nc();
    result_ready_rob2div = 1'b0;
    #1;
    chk("t3_reissue_start", unit_start, 4'b0001);
    chk("t3_next_data", result_ex2rob, 16'h0031);
    nc();
    uop_valid_rs2sch = 1'b0;
    fixed_lat = 0;
    trap_flush_rvv = 1'b1;
    nc();
    trap_flush_rvv = 1'b0;

    // Flush with slot0 DONE, slot1 BUSY; unit1's done lands after the flush
    uop_valid_rs2sch = 1'b1;
    uop_rs2sch = 16'h0041;
    fixed_lat = 2;
    nc();
    uop_rs2sch = 16'h0042;
    fixed_lat = 5;
    nc();
    uop_valid_rs2sch = 1'b0;
    fixed_lat = 0;
    repeat (3) nc();
    #1;
    chk("t4_pre_valid", result_valid_ex2rob, 1'b1);
    trap_flush_rvv = 1'b1;
    nc();
    trap_flush_rvv = 1'b0;
    #1;
    chk("t4_post_valid", result_valid_ex2rob, 1'b0);
    chk("t4_post_idle", div_idle, 1'b1);
    nc();
    #1;
    chk("t4_stale_idle", div_idle, 1'b1);
    uop_valid_rs2sch = 1'b1;
    uop_rs2sch = 16'h0043;
    fixed_lat = 3;
    #1;
    chk("t4_restart", unit_start, 4'b0001);
    nc();
    uop_valid_rs2sch = 1'b0;
    fixed_lat = 0;
    result_ready_rob2div = 1'b1;
    repeat (6) nc();

    // Asynchronous reset with two slots busy and an issue in progress
    uop_valid_rs2sch = 1'b1;
    fixed_lat = 15;
    uop_rs2sch = 16'h0051;
    nc();
    uop_rs2sch = 16'h0052;
    nc();
    uop_valid_rs2sch = 1'b0;
    nc();
    uop_valid_rs2sch = 1'b1;
    uop_rs2sch = 16'h0053;
    #2;
    rst = 1'b1;
    #1;
    rst_outputs("t5_async");
    nc();
    nc();
    rst = 1'b0;
    uop_valid_rs2sch = 1'b0;
    fixed_lat = 0;
    repeat (20) nc();
    #1;
    chk("t5_idle_after_stale", div_idle, 1'b1);

    // Nine uops, random latency and ready, pointers wrap past NU
    random_run(3000, 0, 9);
    chk("t6_pop_count", pops, 9);
    chk("t6_ret_count", rets, 9);

    // Long random run with occasional flushes, then drain
    random_run(2500, 120, -1);
    result_ready_rob2div = 1'b1;
    repeat (40) nc();
    #1;
    chk("t7_drained_idle", div_idle, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
